// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU issue/writeback stage: opcodes, FSM states
// and instruction field positions.
package mcpu_pkg;

   localparam logic [1:0] CMD_AND = 2'b00;
   localparam logic [1:0] CMD_OR  = 2'b01;
   localparam logic [1:0] CMD_XOR = 2'b10;
   localparam logic [1:0] CMD_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

   // Field index within {opcode, dst, srca, srcb}; bit offset = index * REG_ADDR_W.
   localparam int FLD_SRCB = 0;
   localparam int FLD_SRCA = 1;
   localparam int FLD_DST  = 2;
   localparam int FLD_OP   = 3;

endpackage

// File: rtl/mcpu_regfile.sv
// Register file with two combinational read ports and one write port shared
// between writeback and preload.
module mcpu_regfile
   import mcpu_pkg::*;
#(
   parameter int AW = 2,
   parameter int DW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] ra_addr_i,
   output logic [DW-1:0] ra_data_o,
   input  logic [AW-1:0] rb_addr_i,
   output logic [DW-1:0] rb_data_o,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_addr_i,
   input  logic [DW-1:0] wb_data_i,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [DW-1:0] ld_data_i
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;

   assign we    = wb_we_i | ld_we_i;
   assign waddr = wb_we_i ? wb_addr_i : ld_addr_i;
   assign wdata = wb_we_i ? wb_data_i : ld_data_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign ra_data_o = mem_q[ra_addr_i];
   assign rb_data_o = mem_q[rb_addr_i];

   // Preload is only granted in IDLE and writeback only happens in WB.
   a_wr_excl: assert property (@(posedge clk) disable iff (!rst_n) !(wb_we_i && ld_we_i));

endmodule

// File: rtl/mcpu_alu_issue.sv
// Issue/writeback stage around the external MCPU ALU: accepts one instruction
// per three cycles, drives the ALU, captures its result and writes it back.
//
// state | meaning
// IDLE  | ready for an instruction or a preload
// EXEC  | ALU inputs stable, result captured at the exit edge
// WB    | result strobed and written to the register file at the exit edge
module mcpu_alu_issue
   import mcpu_pkg::*;
#(
   parameter int CMD_SIZE   = 2,
   parameter int WORD_SIZE  = 2,
   parameter int REG_ADDR_W = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [CMD_SIZE+3*REG_ADDR_W-1:0] in_instr,
   input  logic                             ld_valid,
   output logic                             ld_ready,
   input  logic [REG_ADDR_W-1:0]            ld_addr,
   input  logic [WORD_SIZE-1:0]             ld_data,
   output logic [CMD_SIZE-1:0]              alu_opcode,
   output logic [WORD_SIZE-1:0]             alu_r1,
   output logic [WORD_SIZE-1:0]             alu_r2,
   input  logic [WORD_SIZE-1:0]             alu_out,
   input  logic                             alu_overflow,
   output logic                             res_valid,
   output logic [WORD_SIZE-1:0]             res_data,
   output logic                             res_ovf,
   output logic                             ovf_flag
);

   state_e                  state_q, state_d;
   logic [CMD_SIZE-1:0]     op_q;
   logic [WORD_SIZE-1:0]    r1_q, r2_q;
   logic [REG_ADDR_W-1:0]   dst_q;
   logic [WORD_SIZE-1:0]    res_data_q;
   logic                    res_ovf_q;
   logic                    ovf_flag_q;

   logic [CMD_SIZE-1:0]     f_op;
   logic [REG_ADDR_W-1:0]   f_dst, f_srca, f_srcb;
   logic [WORD_SIZE-1:0]    rd_a, rd_b;
   logic                    accept, ld_we, wb_we, op_is_add;

   assign f_srcb = in_instr[FLD_SRCB*REG_ADDR_W +: REG_ADDR_W];
   assign f_srca = in_instr[FLD_SRCA*REG_ADDR_W +: REG_ADDR_W];
   assign f_dst  = in_instr[FLD_DST*REG_ADDR_W  +: REG_ADDR_W];
   assign f_op   = in_instr[FLD_OP*REG_ADDR_W   +: CMD_SIZE];

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      ld_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            ld_ready = !in_valid;
            if (in_valid) state_d = EXEC;
         end
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign accept    = in_valid && in_ready;
   assign ld_we     = ld_valid && ld_ready;
   assign wb_we     = (state_q == WB);
   assign op_is_add = (op_q == CMD_SIZE'(CMD_ADD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         r1_q       <= '0;
         r2_q       <= '0;
         dst_q      <= '0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         ovf_flag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= f_op;
            r1_q  <= rd_a;
            r2_q  <= rd_b;
            dst_q <= f_dst;
         end
         if (state_q == EXEC) begin
            res_data_q <= alu_out;
            // Logic ops never report overflow, whatever the ALU drives.
            res_ovf_q  <= alu_overflow && op_is_add;
         end
         if (wb_we && op_is_add) ovf_flag_q <= res_ovf_q;
      end
   end

   mcpu_regfile #(
      .AW (REG_ADDR_W),
      .DW (WORD_SIZE)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_addr_i (f_srca),
      .ra_data_o (rd_a),
      .rb_addr_i (f_srcb),
      .rb_data_o (rd_b),
      .wb_we_i   (wb_we),
      .wb_addr_i (dst_q),
      .wb_data_i (res_data_q),
      .ld_we_i   (ld_we),
      .ld_addr_i (ld_addr),
      .ld_data_i (ld_data)
   );

   // Derived from the async-reset state so a reset in WB drops it immediately.
   assign res_valid  = wb_we;
   assign alu_opcode = op_q;
   assign alu_r1     = r1_q;
   assign alu_r2     = r2_q;
   assign res_data   = res_data_q;
   assign res_ovf    = res_ovf_q;
   assign ovf_flag   = ovf_flag_q;

endmodule

// File: tb/tb_mcpu_alu_issue.sv
// Directed, table-driven bench for mcpu_alu_issue with a behavioural ALU.
module tb_mcpu_alu_issue;
   import mcpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_instr = '0;
   logic       ld_valid = 1'b0;
   logic       ld_ready;
   logic [1:0] ld_addr = '0;
   logic [1:0] ld_data = '0;
   logic [1:0] alu_opcode, alu_r1, alu_r2, alu_out;
   logic       alu_overflow;
   logic       res_valid, res_ovf, ovf_flag;
   logic [1:0] res_data;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mcpu_alu_issue #(.CMD_SIZE(2), .WORD_SIZE(2), .REG_ADDR_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
      .alu_out(alu_out), .alu_overflow(alu_overflow),
      .res_valid(res_valid), .res_data(res_data), .res_ovf(res_ovf), .ovf_flag(ovf_flag)
   );

   always_comb begin
      alu_out      = '0;
      alu_overflow = 1'b0;
      case (alu_opcode)
         CMD_AND: alu_out = alu_r1 & alu_r2;
         CMD_OR:  alu_out = alu_r1 | alu_r2;
         CMD_XOR: alu_out = alu_r1 ^ alu_r2;
         default: {alu_overflow, alu_out} = {1'b0, alu_r1} + {1'b0, alu_r2};
      endcase
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      ld_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic preload(input logic [1:0] a, input logic [1:0] d);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      #1 chk($sformatf("ld_ready R%0d", a), ld_ready, 1);
      @(posedge clk);
      #1 ld_valid = 1'b0;
   endtask

   task automatic issue(input string nm, input logic [1:0] op, input logic [1:0] dst,
                        input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] ed, input logic eo, input logic ef);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = {op, dst, sa, sb};
      #1 chk({nm, ".in_ready_idle"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk({nm, ".alu_opcode"}, alu_opcode, op);
      chk({nm, ".in_ready_exec"}, in_ready, 0);
      chk({nm, ".res_valid_exec"}, res_valid, 0);
      @(posedge clk);
      #1 chk({nm, ".res_valid_wb"}, res_valid, 1);
      chk({nm, ".res_data"}, res_data, ed);
      chk({nm, ".res_ovf"}, res_ovf, eo);
      @(posedge clk);
      #1 chk({nm, ".res_valid_after"}, res_valid, 0);
      chk({nm, ".in_ready_after"}, in_ready, 1);
      chk({nm, ".res_data_hold"}, res_data, ed);
      chk({nm, ".ovf_flag"}, ovf_flag, ef);
   endtask

   typedef struct {
      logic [1:0] op, dst, sa, sb, ed;
      logic       eo, ef;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int accepts, pulses;
      logic prev_rv;

      vecs[0]  = '{CMD_ADD, 2'd2, 2'd0, 2'd1, 2'b00, 1'b1, 1'b1};
      vecs[1]  = '{CMD_OR,  2'd2, 2'd2, 2'd2, 2'b00, 1'b0, 1'b1};
      vecs[2]  = '{CMD_XOR, 2'd3, 2'd0, 2'd1, 2'b10, 1'b0, 1'b1};
      vecs[3]  = '{CMD_ADD, 2'd3, 2'd1, 2'd1, 2'b10, 1'b0, 1'b0};
      vecs[4]  = '{CMD_OR,  2'd3, 2'd3, 2'd3, 2'b10, 1'b0, 1'b0};
      vecs[5]  = '{CMD_AND, 2'd0, 2'd0, 2'd1, 2'b01, 1'b0, 1'b0};
      vecs[6]  = '{CMD_ADD, 2'd1, 2'd1, 2'd1, 2'b10, 1'b0, 1'b0};
      vecs[7]  = '{CMD_AND, 2'd1, 2'd1, 2'd1, 2'b10, 1'b0, 1'b0};
      vecs[8]  = '{CMD_ADD, 2'd2, 2'd1, 2'd1, 2'b00, 1'b1, 1'b1};
      vecs[9]  = '{CMD_XOR, 2'd2, 2'd0, 2'd0, 2'b00, 1'b0, 1'b1};
      vecs[10] = '{CMD_ADD, 2'd3, 2'd3, 2'd0, 2'b11, 1'b0, 1'b0};
      vecs[11] = '{CMD_OR,  2'd0, 2'd3, 2'd1, 2'b11, 1'b0, 1'b0};

      do_reset();
      #1;
      chk("rst.res_valid", res_valid, 0);
      chk("rst.res_data", res_data, 0);
      chk("rst.res_ovf", res_ovf, 0);
      chk("rst.ovf_flag", ovf_flag, 0);
      chk("rst.alu_opcode", alu_opcode, 0);
      chk("rst.alu_r1", alu_r1, 0);
      chk("rst.alu_r2", alu_r2, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.ld_ready", ld_ready, 1);

      preload(2'd0, 2'b11);
      preload(2'd1, 2'b01);
      for (int i = 0; i < 12; i++)
         issue($sformatf("v%0d", i), vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb,
               vecs[i].ed, vecs[i].eo, vecs[i].ef);
      // Registers now: R0=3 R1=2 R2=0 R3=3, ovf_flag=0.

      // Back-to-back: in_valid held for 9 cycles -> 3 accepts, 3 single-cycle pulses.
      accepts = 0;
      pulses  = 0;
      prev_rv = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = {CMD_OR, 2'd0, 2'd0, 2'd0};
      for (int c = 0; c < 9; c++) begin
         #1;
         if (in_ready) accepts++;
         if (res_valid) begin
            pulses++;
            chk($sformatf("b2b.res_data c%0d", c), res_data, 3);
            chk($sformatf("b2b.single_pulse c%0d", c), prev_rv, 0);
         end
         chk($sformatf("b2b.ld_ready c%0d", c), ld_ready, 0);
         prev_rv = res_valid;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("b2b.accepts", accepts, 3);
      chk("b2b.pulses", pulses, 3);

      // Instruction wins over a simultaneous preload; preload lands in first free IDLE cycle.
      in_valid = 1'b1;
      in_instr = {CMD_XOR, 2'd2, 2'd0, 2'd1};
      ld_valid = 1'b1;
      ld_addr  = 2'd0;
      ld_data  = 2'b10;
      #1 chk("prio.ld_ready_idle", ld_ready, 0);
      chk("prio.in_ready_idle", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("prio.ld_ready_exec", ld_ready, 0);
      @(posedge clk);
      #1 chk("prio.res_valid", res_valid, 1);
      chk("prio.res_data", res_data, 1);
      chk("prio.ld_ready_wb", ld_ready, 0);
      @(posedge clk);
      #1 chk("prio.ld_ready_back", ld_ready, 1);
      @(posedge clk);
      #1 ld_valid = 1'b0;
      issue("prio.r0", CMD_OR, 2'd0, 2'd0, 2'd0, 2'b10, 1'b0, 1'b0);
      issue("prio.r2", CMD_OR, 2'd2, 2'd2, 2'd2, 2'b01, 1'b0, 1'b0);

      // Reset during EXEC of ADD R0=R0+R1.
      do_reset();
      preload(2'd1, 2'b01);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = {CMD_ADD, 2'd0, 2'd0, 2'd1};
      @(posedge clk);
      #1 in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("rexec.res_valid", res_valid, 0);
      chk("rexec.in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (res_valid) pulses++;
      end
      chk("rexec.no_pulse", pulses, 0);
      chk("rexec.ovf_flag", ovf_flag, 0);
      issue("rexec.r0", CMD_OR, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 1'b0);

      // Reset during WB of ADD R2=R1+R1 (would overflow).
      preload(2'd1, 2'b11);
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = {CMD_ADD, 2'd2, 2'd1, 2'd1};
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 chk("rwb.res_valid_wb", res_valid, 1);
      chk("rwb.res_data_wb", res_data, 2);
      rst_n = 1'b0;
      #1 chk("rwb.res_valid_async", res_valid, 0);
      chk("rwb.ovf_flag", ovf_flag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue("rwb.r2", CMD_OR, 2'd2, 2'd2, 2'd2, 2'b00, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
